mac_dot_seq: RTL
================

Name: mac_dot_seq

Overview:
- Sequencer that runs an N-element unsigned dot product on the team's 8-bit Vedic multiply / accumulate datapath.
- Accepts a job (start + length), pulls operand pairs over a valid/ready stream, clears and gates the accumulator, and presents the final sum on a held valid/ready result port.
- Sits between a DMA/operand buffer and downstream result logic; replaces free-running MAC accumulation with controlled, job-bounded accumulation.

Parameters:
- DATA_W, 8, operand width (product width 2*DATA_W).
- ACC_W, 20, accumulator/result width, must be >= 2*DATA_W.
- LEN_W, 8, width of job length field (max 2^LEN_W-1 beats).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs for job; sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_a  in  DATA_W  operand A, unsigned.
- in_b  in  DATA_W  operand B, unsigned.
- res_valid  out  1  result valid, held until taken.
- res_ready  in  1  result consumer ready.
- result  out  ACC_W  dot-product sum modulo 2^ACC_W.
- ovf  out  1  sticky: sum exceeded 2^ACC_W-1 during the job.

Behaviour:
- Reset (rst=1 at edge, any state including mid-job):
  - FSM to IDLE; beat counter 0, product stage empty, accumulator 0.
  - busy=0, in_ready=0, res_valid=0, result=0, ovf=0.
  - Partial job discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and len!=0 -> clear accumulator and ovf, load counter=len, go RUN.
  - start=1 and len==0 -> accumulator 0, ovf 0, go DONE directly.
- RUN:
  - in_ready=1.
  - Each handshake: register product in_a*in_b (stage 1), decrement counter.
  - Handshake with counter==1 -> go DRAIN.
  - in_valid gaps allowed: a bubble enters the stage, no accumulate.
- Pipeline:
  - Stage 1 = product register plus valid bit.
  - Stage 2 = acc <= acc + zero-extended product when stage-1 valid.
  - Carry out of bit ACC_W-1 sets ovf (sticky); acc wraps modulo 2^ACC_W.
- DRAIN:
  - in_ready=0; wait until stage 1 empty and final add done, then DONE.
- Timing: last beat accepted at edge t -> res_valid=1 after edge t+2 (two-cycle latency). Fixed for any gap pattern.
- DONE:
  - res_valid=1; result and ovf stable.
  - res_valid & res_ready at an edge -> IDLE, res_valid=0. Result/ovf keep last values until next start.
- start outside IDLE ignored, no queuing. start asserted in the same cycle as the result handshake is also ignored (FSM still DONE).
- in_ready never 1 outside RUN; in_a/in_b ignored when no handshake.
- Max job length 2^LEN_W-1 (255) beats; no internal limit beyond counter width.

Decomposition:
- Package mac_seq_pkg: state encoding enum (IDLE, RUN, DRAIN, DONE), default widths DATA_W/ACC_W/LEN_W as localparams.
- Sub-module: instantiate the existing 8-bit Vedic multiplier (Vedic_Mult8) for stage 1.
- Keep the accumulator add inline (ACC_W-wide, carry-out used for ovf); FSM and counter in top.
- Estimated 150-250 lines RTL.

Test Plan:
- len=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, res_ready=1 -> result=100, ovf=0, res_valid exactly 2 cycles after 4th handshake.
- len=17, all pairs (255,255) -> true sum 1105425, result=56849 (mod 2^20), ovf=1.
- len=0 with start -> DONE next cycle, result=0, ovf=0, no in_ready pulse.
- len=3, pairs (10,10),(20,20),(30,30) with 2-cycle in_valid gaps, res_ready held low 5 cycles -> result=1400 held stable, busy=1 until handshake, then IDLE.
- Start len=5, rst after 2 beats, then start len=1 pair (9,9) -> result=81, ovf=0, no residue from aborted job.
- start pulsed during RUN/DONE of a len=2 job (2,3),(4,5) -> ignored, result=26, exactly one job completes.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared definitions for the mac_dot_seq dot-product sequencer.
//   - Default datapath widths (operand, accumulator, job length).
//   - FSM state encoding used by the sequencer top.
package mac_seq_pkg;

  localparam int unsigned DefDataW = 8;   // operand width
  localparam int unsigned DefAccW  = 20;  // accumulator / result width
  localparam int unsigned DefLenW  = 8;   // job length field width

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_dot_seq_if.sv
// Operand stream and result port of the dot-product sequencer.
//   in_valid/in_ready/in_a/in_b : operand-pair stream (source -> sequencer)
//   res_valid/res_ready/result/ovf : held result port (sequencer -> consumer)
// Modports: master = operand source / result consumer, slave = sequencer.
interface mac_dot_seq_if
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  result;
  logic              ovf;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, result, ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, result, ovf
  );

endinterface

// File: rtl/Vedic_Mult8.sv
// Combinational 8x8 unsigned Vedic (Urdhva Tiryagbhyam) multiplier.
// Built hierarchically: 2x2 gate-level cells -> 4x4 -> 8x8, each level
// summing four half-width partial products.
//   a, b : 8-bit unsigned operands
//   p    : 16-bit unsigned product
module Vedic_Mult8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] r;
    logic       c;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c    = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c;
    r[3] = (x[1] & y[1]) & c;
    return r;
  endfunction

  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vm2(x[1:0], y[1:0]);
    q1 = vm2(x[3:2], y[1:0]);
    q2 = vm2(x[1:0], y[3:2]);
    q3 = vm2(x[3:2], y[3:2]);
    return {q3, 4'b0000} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {4'b0000, q0};
  endfunction

  function automatic logic [15:0] vm8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q0, q1, q2, q3;
    q0 = vm4(x[3:0], y[3:0]);
    q1 = vm4(x[7:4], y[3:0]);
    q2 = vm4(x[3:0], y[7:4]);
    q3 = vm4(x[7:4], y[7:4]);
    return {q3, 8'h00} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0} + {8'h00, q0};
  endfunction

  always_comb begin
    p = vm8(a, b);
  end

endmodule

// File: rtl/mac_dot_seq.sv
// Job-bounded unsigned dot-product sequencer on an 8-bit Vedic MAC datapath.
//   clk, rst : clock and synchronous active-high reset
//   start    : job request, honoured only in IDLE
//   len      : number of operand pairs, sampled with start (0 = empty job)
//   busy     : high in every state except IDLE
//   bus      : operand stream in, held result/ovf out (slave modport)
// Pipeline: stage 1 registers the product of each accepted pair, stage 2
// adds it into the accumulator. The result appears two edges after the
// last accepted beat regardless of input gaps. DATA_W must be 8 to match
// the multiplier; ACC_W must be at least 2*DATA_W.
module mac_dot_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  mac_dot_seq_if.slave     bus
);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W-1:0]  prod_q, prod_d, mult_p;
  logic                 pvalid_q, pvalid_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 acc_clr;
  logic                 fire;
  logic [ACC_W:0]       sum;

  Vedic_Mult8 u_mult (
    .a (bus.in_a),
    .b (bus.in_b),
    .p (mult_p)
  );

  assign fire = bus.in_valid && (state_q == StRun);

  // Sequencer FSM and beat counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_clr = 1'b1;
          if (len != '0) begin
            cnt_d   = len;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (fire) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      // Last product was registered on entry; leave once the add has consumed it.
      StDrain: begin
        if (!pvalid_q) state_d = StDone;
      end
      StDone: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: product register; holds its value across bubbles
  always_comb begin
    pvalid_d = fire;
    prod_d   = fire ? mult_p : prod_q;
  end

  // Stage 2: accumulate with sticky carry-out
  always_comb begin
    sum   = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (acc_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (pvalid_q) begin
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q | sum[ACC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      prod_q   <= '0;
      pvalid_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      pvalid_q <= pvalid_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    bus.in_ready  = (state_q == StRun);
    bus.res_valid = (state_q == StDone);
    bus.result    = acc_q;
    bus.ovf       = ovf_q;
  end

endmodule
